// File: rtl/rrc_interp_fir_pkg.sv
// Shared definitions for the RRC polyphase interpolator: symbol codes,
// FSM encoding and width helpers used by the top level and the coefficient bank.
package rrc_interp_fir_pkg;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b11;
  localparam logic [1:0] SYM_ZERO = 2'b00;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int safe_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accumulator width: coefficient plus growth for TAPS_PER_PHASE terms plus sign.
  function automatic int acc_width(input int coeff_w, input int taps);
    return coeff_w + ((taps > 1) ? $clog2(taps) : 0) + 1;
  endfunction

endpackage

// File: rtl/rrc_interp_fir_coef_bank.sv
// Runtime-writable coefficient register file, cleared by reset,
// with a gated write port and an asynchronous (combinational) read port.
module rrc_interp_fir_coef_bank
  import rrc_interp_fir_pkg::*;
#(
  parameter int NUM_TAPS    = 40,
  parameter int COEFF_WIDTH = 14,
  parameter int AW          = safe_w(NUM_TAPS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_we,
  input  logic [AW-1:0]                 i_waddr,
  input  logic signed [COEFF_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]                 i_raddr,
  output logic signed [COEFF_WIDTH-1:0] o_rdata
);

  logic signed [COEFF_WIDTH-1:0] r_coef [NUM_TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) r_coef[i] <= '0;
    end else if (i_we && (int'(i_waddr) < NUM_TAPS)) begin
      r_coef[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (int'(i_raddr) < NUM_TAPS) ? r_coef[i_raddr] : '0;

endmodule

// File: rtl/rrc_interp_fir.sv
// Multi-channel polyphase RRC interpolator: one 2-bit symbol per channel in,
// SPS scaled samples out, one tap per cycle through an add/subtract accumulator.
module rrc_interp_fir
  import rrc_interp_fir_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int SPS            = 10,
  parameter int TAPS_PER_PHASE = 4,
  parameter int COEFF_WIDTH    = 14,
  parameter int OUTPUT_WIDTH   = 16,
  parameter int OUT_SHIFT      = 0,
  localparam int NUM_TAPS      = SPS * TAPS_PER_PHASE,
  localparam int AW            = safe_w(NUM_TAPS),
  localparam int PW            = safe_w(SPS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2*NUM_CH-1:0]            in_sym,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUTPUT_WIDTH*NUM_CH-1:0] out_data,
  output logic [PW-1:0]                  out_phase,
  input  logic                           coef_we,
  input  logic [AW-1:0]                  coef_addr,
  input  logic [COEFF_WIDTH-1:0]         coef_data
);

  localparam int     KW      = safe_w(TAPS_PER_PHASE);
  localparam int     ACC_W   = acc_width(COEFF_WIDTH, TAPS_PER_PHASE);
  localparam longint RND     = (longint'(1) << OUT_SHIFT) >> 1;
  localparam longint SAT_MAX = (longint'(1) << (OUTPUT_WIDTH - 1)) - 1;
  localparam longint SAT_MIN = -SAT_MAX - 1;

  function automatic longint f_round(input logic signed [ACC_W-1:0] acc);
    return (longint'(acc) + RND) >>> OUT_SHIFT;
  endfunction

  // Clamping never triggers when OUTPUT_WIDTH covers the accumulator, which
  // makes this a plain sign extension in that case.
  function automatic logic signed [OUTPUT_WIDTH-1:0] f_sat(input longint v);
    longint c;
    c = v;
    if (c > SAT_MAX) c = SAT_MAX;
    else if (c < SAT_MIN) c = SAT_MIN;
    return OUTPUT_WIDTH'(c);
  endfunction

  state_t                        r_state, w_state_nxt;
  logic [PW-1:0]                 r_phase;
  logic [KW-1:0]                 r_k;
  logic [1:0]                    r_dly [NUM_CH][TAPS_PER_PHASE];
  logic signed [ACC_W-1:0]       r_acc [NUM_CH];
  logic signed [ACC_W-1:0]       w_acc_nxt [NUM_CH];
  logic [OUTPUT_WIDTH*NUM_CH-1:0] r_out_data;
  logic [PW-1:0]                 r_out_phase;
  logic [AW-1:0]                 w_raddr;
  logic signed [COEFF_WIDTH-1:0] w_coef;
  logic                          w_coef_we;
  logic                          w_last_tap;
  logic                          w_last_phase;

  assign in_ready     = (r_state == S_WAIT);
  assign out_valid    = (r_state == S_OUT);
  assign out_data     = r_out_data;
  assign out_phase    = r_out_phase;
  assign w_last_tap   = (r_k == KW'(TAPS_PER_PHASE - 1));
  assign w_last_phase = (r_phase == PW'(SPS - 1));
  // A write on the same edge as a symbol accept would race the MAC start, so it is dropped.
  assign w_coef_we    = coef_we && in_ready && !in_valid;
  assign w_raddr      = AW'(int'(r_phase) + int'(r_k) * SPS);

  rrc_interp_fir_coef_bank #(
    .NUM_TAPS    (NUM_TAPS),
    .COEFF_WIDTH (COEFF_WIDTH),
    .AW          (AW)
  ) u_coef_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_coef_we),
    .i_waddr (coef_addr),
    .i_wdata (coef_data),
    .i_raddr (w_raddr),
    .o_rdata (w_coef)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT:  if (in_valid) w_state_nxt = S_MAC;
      S_MAC:   if (w_last_tap) w_state_nxt = S_OUT;
      S_OUT:   if (out_ready) w_state_nxt = w_last_phase ? S_WAIT : S_MAC;
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // Multiply by +1/-1/0 reduces to add, subtract or hold; code 10 is illegal and treated as zero.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_acc_nxt[c] = r_acc[c];
      case (r_dly[c][r_k])
        SYM_POS:  w_acc_nxt[c] = r_acc[c] + ACC_W'(w_coef);
        SYM_NEG:  w_acc_nxt[c] = r_acc[c] - ACC_W'(w_coef);
        SYM_ZERO: w_acc_nxt[c] = r_acc[c];
        default:  w_acc_nxt[c] = r_acc[c];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT;
      r_phase     <= '0;
      r_k         <= '0;
      r_out_data  <= '0;
      r_out_phase <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_acc[c] <= '0;
        for (int k = 0; k < TAPS_PER_PHASE; k++) r_dly[c][k] <= 2'b00;
      end
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_WAIT: begin
          if (in_valid) begin
            r_phase <= '0;
            r_k     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
              r_acc[c]    <= '0;
              r_dly[c][0] <= in_sym[2*c +: 2];
              for (int k = 1; k < TAPS_PER_PHASE; k++) r_dly[c][k] <= r_dly[c][k-1];
            end
          end
        end
        S_MAC: begin
          r_k <= r_k + KW'(1);
          for (int c = 0; c < NUM_CH; c++) r_acc[c] <= w_acc_nxt[c];
          if (w_last_tap) begin
            r_out_phase <= r_phase;
            for (int c = 0; c < NUM_CH; c++)
              r_out_data[c*OUTPUT_WIDTH +: OUTPUT_WIDTH] <= f_sat(f_round(w_acc_nxt[c]));
          end
        end
        S_OUT: begin
          if (out_ready && !w_last_phase) begin
            r_phase <= r_phase + PW'(1);
            r_k     <= '0;
            for (int c = 0; c < NUM_CH; c++) r_acc[c] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rrc_interp_fir.md
Name: rrc_interp_fir

Overview:
- Multi-channel polyphase root-raised-cosine interpolating filter for the BPSK/QPSK transmit path.
- Accepts one 2-bit symbol per channel per handshake and emits SPS filtered samples per symbol, one polyphase branch at a time.
- Uses a time-multiplexed add/subtract accumulator, a runtime-writable coefficient bank, valid/ready on both sides, and round/saturate output scaling.

Parameters:
- NUM_CH, 2: number of parallel channels (I/Q); all channels share one coefficient set.
- SPS, 10: samples per symbol, which is also the polyphase branch count.
- TAPS_PER_PHASE, 4: taps per branch, so NUM_TAPS = SPS*TAPS_PER_PHASE = 40.
- COEFF_WIDTH, 14: signed coefficient width.
- OUTPUT_WIDTH, 16: signed output sample width per channel.
- OUT_SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  symbol valid
- in_ready  out  1  block can accept a symbol
- in_sym  in  2*NUM_CH  channel c is in bits [2c+1:2c]
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the sample
- out_data  out  OUTPUT_WIDTH*NUM_CH  signed samples; channel c is in slice c
- out_phase  out  $clog2(SPS)  polyphase index of the current out_data
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(NUM_TAPS)  tap index, 0..NUM_TAPS-1
- coef_data  in  COEFF_WIDTH  signed coefficient

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - state = S_WAIT; in_ready = 1; out_valid = 0; out_data = 0; out_phase = 0.
  - All coefficients = 0; all delay-line entries = 00; accumulators = 0.
- Symbol encoding: 01 = +1, 11 = -1, 00 = 0, 10 = 0 (illegal code, treated as zero).
- Delay line: TAPS_PER_PHASE entries per channel; d[0] holds the newest symbol. A new symbol shifts d[k] into d[k+1] and the oldest entry is dropped.
- Filter equation: branch p output y_c[p] = sum over k of h[p + k*SPS] * d_c[k], for k = 0..TAPS_PER_PHASE-1. Each multiply is implemented as add, subtract or skip.
- Accumulator: ACC_W = COEFF_WIDTH + $clog2(TAPS_PER_PHASE) + 1, signed, so it never overflows.
- Output scaling:
  - If OUT_SHIFT > 0, add 1<<(OUT_SHIFT-1), then arithmetic shift right by OUT_SHIFT.
  - Saturate to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
  - If OUTPUT_WIDTH >= ACC_W, sign-extend instead of saturating.
- FSM states: S_WAIT, S_MAC, S_OUT.
  - S_WAIT: in_ready = 1. On in_valid at an edge: shift in the symbol, set phase = 0, k = 0, clear the accumulators, go to S_MAC.
  - S_MAC: one tap per cycle, k = 0..TAPS_PER_PHASE-1. The edge that adds tap TAPS_PER_PHASE-1 also registers the scaled result into out_data and out_phase, then goes to S_OUT.
  - S_OUT: out_valid = 1; out_data and out_phase are held stable while out_ready = 0.
  - On the S_OUT handshake: if phase == SPS-1, go to S_WAIT. Otherwise increment phase, clear k and the accumulators, go to S_MAC.
- in_ready is 0 in S_MAC and S_OUT.
- Latency: out_valid rises TAPS_PER_PHASE edges after the accepting edge (4 by default).
- Throughput with out_ready held at 1:
  - Samples are TAPS_PER_PHASE+1 cycles apart.
  - One symbol occupies 1 + SPS*(TAPS_PER_PHASE+1) - 1 = 50 cycles at defaults. in_ready re-asserts on the cycle after the last handshake.
- Coefficient writes:
  - Honoured only in S_WAIT, and only when the same edge does not accept a symbol. They are silently dropped otherwise.
  - The written value is visible to a MAC started from the next edge.
  - coef_addr >= NUM_TAPS is ignored.
- Reset mid-operation: all state clears immediately. out_valid drops asynchronously and any partial sample is discarded.
- All registers are updated only on the clk edge or on asynchronous reset; there are no combinational paths from inputs to outputs except in_ready and out_valid, which are functions of state alone.

Decomposition:
- Shared header rrc_defs.vh holds:
  - Symbol code constants: SYM_POS = 2'b01, SYM_NEG = 2'b11, SYM_ZERO = 2'b00.
  - FSM state encodings.
  - A clog2-safe width macro for ACC_W.
- One sub-module, rrc_coef_bank:
  - NUM_TAPS x COEFF_WIDTH register file with async-reset-to-zero.
  - Gated write port; combinational read by index p + k*SPS.
- The top level holds the FSM, delay lines, per-channel accumulators and output scaling.

Test Plan:
- Reset: drive rst_n = 0 for 2 cycles -> in_ready = 1, out_valid = 0, out_data = 0, out_phase = 0.
- Impulse: write h[i] = i+1 for i = 0..39; send ch0 = 01, ch1 = 00; hold out_ready = 1.
  - First out_valid 4 edges after accept.
  - 10 samples with ch0 = 1..10 and ch1 = 0; out_phase 0..9.
  - in_ready returns high afterwards.
- Superposition: after the impulse, send ch0 = 11 -> ch0 sample at phase p = -(p+1) + (p+11) = 10 for all p.
- Backpressure: pull out_ready low for 3 cycles at phase 4 -> out_data and out_phase = 4 stay stable, in_ready = 0, no sample is lost; phase 5 follows the release.
- Saturation: instance with OUTPUT_WIDTH = 14; all h = 8191; four 01 symbols -> 8191; four 11 symbols -> -8192. Instance with OUT_SHIFT = 2 and sum 6 -> output 2 (round-half-up).
- Mid-operation events:
  - coef_we during S_MAC is ignored: readback via impulse is unchanged.
  - rst_n pulsed in S_MAC drops out_valid immediately, and a subsequent impulse yields all zeros.
